trng_conditioner: RTL and testbench
===================================

TRNG_CONDITIONER -- requirements
Module: trng_conditioner

Interface
REQ-001 Parameter SAMPLE_DIV, default 16, clk cycles per raw-bit sample; legal range 1..1024.
REQ-002 Parameter REP_LIMIT, default 32, consecutive identical raw samples that trip the stuck-source fault; legal range 2..255.
REQ-003 clk  input  1  sole clock, all state rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rnd_in  input  1  raw ring-oscillator bit, asynchronous to clk.
REQ-006 enable  input  1  high = sampling active.
REQ-007 byte_out  output  8  conditioned random byte.
REQ-008 byte_valid  output  1  byte_out holds an unconsumed byte.
REQ-009 byte_ready  input  1  consumer (UART transmitter) accepts byte_out this cycle.
REQ-010 overflow  output  1  sticky: at least one completed byte was dropped.
REQ-011 stuck_fault  output  1  sticky: repetition health test failed.

Function
REQ-012 rnd_in shall pass through a two-flop synchronizer before any use; only the second-stage value (sync bit) is sampled.
REQ-013 Divider counts 0..SAMPLE_DIV-1 while enable=1; sample tick occurs in the cycle the count equals SAMPLE_DIV-1, then wraps to 0; SAMPLE_DIV=1 gives a tick every enabled cycle.
REQ-014 enable=0: divider held at 0, no ticks, von Neumann phase returns to FIRST; shift register, bit count, output register and sticky flags retained.
REQ-015 Von Neumann FSM states FIRST, SECOND: tick in FIRST stores sync bit as a, goes to SECOND; tick in SECOND compares sync bit b with a, goes to FIRST.
REQ-016 Pair (a,b): (1,0) emits bit 1; (0,1) emits bit 0; (0,0) and (1,1) emit nothing.
REQ-017 Emitted bit shifts into bit 0 of an 8-bit shift register, existing contents shift left; first emitted bit of a byte ends in bit 7.
REQ-018 3-bit bit counter increments per emitted bit; on the 8th bit the completed byte (including that bit) is offered to the output register and the counter wraps to 0.
REQ-019 Output register loads the completed byte and byte_valid rises in the cycle after the completing tick if byte_valid=0, or if byte_valid=1 and byte_ready=1 in the completing cycle.
REQ-020 Completed byte arriving while byte_valid=1 and byte_ready=0: byte discarded, overflow set, output register unchanged.
REQ-021 Handshake: transfer occurs on a cycle with byte_valid=1 and byte_ready=1; byte_valid falls next cycle unless REQ-019 reloads it; byte_out stable while byte_valid=1 and byte_ready=0.
REQ-022 byte_ready while byte_valid=0 has no effect.
REQ-023 Repetition test: per tick, if sync bit equals previous tick's sync bit, run counter increments (saturating at REP_LIMIT), else reset to 1; first tick after reset or enable rise starts at 1.
REQ-024 Run counter reaching REP_LIMIT sets stuck_fault in the cycle after that tick.
REQ-025 stuck_fault=1: no further bytes loaded into the output register; a byte already valid may still complete its handshake.
REQ-026 Sampling, health test and bytes are independent of byte_ready; upstream is never stalled.

Reset
REQ-027 rst=1 at a clk edge: synchronizer, divider, FSM (FIRST), shift register, bit counter, run counter cleared; byte_out=0x00, byte_valid=0, overflow=0, stuck_fault=0 from the next cycle.
REQ-028 rst mid-byte or with byte_valid=1 discards all partial and pending data; no byte is emitted from pre-reset samples.
REQ-029 rst overrides enable and byte_ready in the same cycle.

Verification
REQ-030 SAMPLE_DIV=1, byte_ready=1, samples pairs 10,01,10,01,01,10,01,10 -> byte_out=0xA5, byte_valid one cycle after 16th tick, one cycle high.
REQ-031 Same pairs interleaved with 00 and 11 pairs -> still exactly one byte 0xA5; discarded pairs change nothing.
REQ-032 byte_ready=0, pair stream yielding 0x3C then 0xC3 -> byte_out stays 0x3C, overflow=1 after second byte; byte_ready=1 -> one transfer of 0x3C, byte_valid then 0.
REQ-033 rnd_in held 1, REP_LIMIT=32, SAMPLE_DIV=4 -> stuck_fault=1 one cycle after 32nd tick (cycle ~130 incl. synchronizer); no byte_valid thereafter.
REQ-034 rst after 5 emitted bits, then 8 fresh bits 0xFF -> byte_out=0xFF, no pre-reset bits present.
REQ-035 SAMPLE_DIV=16, enable dropped after first sample of a pair for 40 cycles, re-raised -> next tick treated as FIRST; tick spacing exactly 16 cycles after re-enable.

Source files
------------

// File: rtl/trng_conditioner.sv
// Purpose: conditions a raw ring-oscillator bit into bytes (2-flop sync, divider, von Neumann, repetition health test).
// Latency: a byte is presented one cycle after the sample tick that completes it.
// Backpressure: none upstream; a byte completing while the output is still held is dropped and flagged in overflow.
module trng_conditioner #(
   parameter int SAMPLE_DIV = 16,
   parameter int REP_LIMIT  = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rnd_in,
   input  logic       enable,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       overflow,
   output logic       stuck_fault
);

   localparam int               DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [7:0]       REP_MAX  = 8'(REP_LIMIT);

   // von Neumann pairing phase
   localparam logic [0:0] ST_FIRST  = 1'b0;
   localparam logic [0:0] ST_SECOND = 1'b1;

   logic             sync_q1;
   logic             sync_q2;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [0:0]       vn_state;
   logic             vn_a;
   logic [7:0]       shift_q;
   logic [2:0]       bit_cnt;
   logic [7:0]       run_cnt;
   logic [7:0]       run_next;
   logic             prev_bit;
   logic             rep_first;
   logic             emit;
   logic             byte_done;
   logic [7:0]       shift_next;

   // The bit emitted for an unequal pair is the first sample: (1,0) -> 1, (0,1) -> 0.
   assign tick       = enable && (div_cnt == DIV_LAST);
   assign emit       = tick && (vn_state == ST_SECOND) && (vn_a != sync_q2);
   assign shift_next = {shift_q[6:0], vn_a};
   assign byte_done  = emit && (bit_cnt == 3'd7);

   // Next run length of identical samples, saturating at the fault threshold
   always_comb begin
      run_next = run_cnt;
      if (rep_first || (sync_q2 != prev_bit)) begin
         run_next = 8'd1;
      end else if (run_cnt < REP_MAX) begin
         run_next = run_cnt + 8'd1;
      end
   end

   // Two-flop synchronizer for the asynchronous raw bit
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= rnd_in;
         sync_q2 <= sync_q1;
      end
   end

   // Sample divider: held at zero while disabled, wraps after the tick cycle
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Von Neumann pairing; disabling restarts pairing so a stale first sample is never reused
   always_ff @(posedge clk) begin
      if (rst) begin
         vn_state <= ST_FIRST;
         vn_a     <= 1'b0;
      end else if (!enable) begin
         vn_state <= ST_FIRST;
      end else if (tick) begin
         if (vn_state == ST_FIRST) begin
            vn_a     <= sync_q2;
            vn_state <= ST_SECOND;
         end else begin
            vn_state <= ST_FIRST;
         end
      end
   end

   // Byte assembly: emitted bits enter at bit 0, the first bit of a byte ends in bit 7
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= 8'h00;
         bit_cnt <= 3'd0;
      end else if (emit) begin
         shift_q <= shift_next;
         bit_cnt <= bit_cnt + 3'd1;
      end
   end

   // Repetition health test; the first tick after reset or re-enable starts a fresh run
   always_ff @(posedge clk) begin
      if (rst) begin
         run_cnt   <= 8'd0;
         prev_bit  <= 1'b0;
         rep_first <= 1'b1;
      end else if (!enable) begin
         rep_first <= 1'b1;
      end else if (tick) begin
         run_cnt   <= run_next;
         prev_bit  <= sync_q2;
         rep_first <= 1'b0;
      end
   end

   // Sticky stuck-source flag
   always_ff @(posedge clk) begin
      if (rst) begin
         stuck_fault <= 1'b0;
      end else if (tick && (run_next == REP_MAX)) begin
         stuck_fault <= 1'b1;
      end
   end

   // Output holding register with valid/ready handshake and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_out   <= 8'h00;
         byte_valid <= 1'b0;
         overflow   <= 1'b0;
      end else if (byte_done && !stuck_fault && (!byte_valid || byte_ready)) begin
         byte_out   <= shift_next;
         byte_valid <= 1'b1;
      end else begin
         if (byte_done && !stuck_fault) begin
            overflow <= 1'b1;
         end
         if (byte_valid && byte_ready) begin
            byte_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_trng_conditioner.sv
// Purpose: checks trng_conditioner at three sample dividers against a sample-level model and literal expectations.
// Latency: outputs compared every cycle on the falling edge.
// Backpressure: byte_ready driven directly by the stimulus.
module tb_trng_conditioner;

   logic clk = 1'b0;
   logic rst;
   logic rnd_in;
   logic enable;
   logic byte_ready;

   logic [7:0] bo1, bo4, bo16;
   logic       bv1, bv4, bv16;
   logic       ov1, ov4, ov16;
   logic       sf1, sf4, sf16;

   always #5 clk = ~clk;

   trng_conditioner #(.SAMPLE_DIV(1), .REP_LIMIT(32)) u_div1 (
      .clk(clk), .rst(rst), .rnd_in(rnd_in), .enable(enable),
      .byte_out(bo1), .byte_valid(bv1), .byte_ready(byte_ready),
      .overflow(ov1), .stuck_fault(sf1));

   trng_conditioner #(.SAMPLE_DIV(4), .REP_LIMIT(32)) u_div4 (
      .clk(clk), .rst(rst), .rnd_in(rnd_in), .enable(enable),
      .byte_out(bo4), .byte_valid(bv4), .byte_ready(byte_ready),
      .overflow(ov4), .stuck_fault(sf4));

   trng_conditioner #(.SAMPLE_DIV(16), .REP_LIMIT(32)) u_div16 (
      .clk(clk), .rst(rst), .rnd_in(rnd_in), .enable(enable),
      .byte_out(bo16), .byte_valid(bv16), .byte_ready(byte_ready),
      .overflow(ov16), .stuck_fault(sf16));

   logic [7:0] d_out [3];
   logic       d_vld [3];
   logic       d_ovf [3];
   logic       d_stk [3];
   assign d_out[0] = bo1;  assign d_out[1] = bo4;  assign d_out[2] = bo16;
   assign d_vld[0] = bv1;  assign d_vld[1] = bv4;  assign d_vld[2] = bv16;
   assign d_ovf[0] = ov1;  assign d_ovf[1] = ov4;  assign d_ovf[2] = ov16;
   assign d_stk[0] = sf1;  assign d_stk[1] = sf4;  assign d_stk[2] = sf16;

   int errors = 0;
   int checks = 0;
   bit cmp_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- sample-level model ----------------
   int       m_div [3] = '{1, 4, 16};
   int       m_en_cnt [3];
   bit       m_have_a [3];
   bit       m_a [3];
   int       m_nbits [3];
   bit [7:0] m_acc [3];
   bit       m_prev [3];
   int       m_run [3];
   bit       m_first [3];
   bit       m_valid [3];
   bit [7:0] m_data [3];
   bit       m_ovf [3];
   bit       m_stuck [3];
   bit       dly0, dly1;

   task automatic model_step();
      bit       sb;
      bit       tk;
      bit       done;
      bit       stuck_new;
      bit       old_valid;
      bit [7:0] byt;
      sb = dly1;
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_en_cnt[i] = 0; m_have_a[i] = 0; m_a[i] = 0; m_nbits[i] = 0; m_acc[i] = 0;
            m_prev[i] = 0; m_run[i] = 0; m_first[i] = 1; m_valid[i] = 0; m_data[i] = 0;
            m_ovf[i] = 0; m_stuck[i] = 0;
         end else begin
            tk        = enable && ((m_en_cnt[i] % m_div[i]) == m_div[i] - 1);
            done      = 0;
            byt       = 0;
            stuck_new = m_stuck[i];
            old_valid = m_valid[i];
            if (tk) begin
               if (m_first[i] || sb != m_prev[i]) m_run[i] = 1;
               else if (m_run[i] < 32) m_run[i]++;
               m_prev[i]  = sb;
               m_first[i] = 0;
               if (m_run[i] == 32) stuck_new = 1;
               if (!m_have_a[i]) begin
                  m_a[i] = sb;
                  m_have_a[i] = 1;
               end else begin
                  m_have_a[i] = 0;
                  if (m_a[i] != sb) begin
                     m_acc[i] = {m_acc[i][6:0], m_a[i]};
                     m_nbits[i]++;
                     if (m_nbits[i] == 8) begin
                        done = 1;
                        byt = m_acc[i];
                        m_nbits[i] = 0;
                     end
                  end
               end
            end
            if (enable) m_en_cnt[i]++;
            else begin
               m_en_cnt[i] = 0;
               m_have_a[i] = 0;
               m_first[i]  = 1;
            end
            if (done && !m_stuck[i]) begin
               if (!old_valid || byte_ready) begin
                  m_data[i]  = byt;
                  m_valid[i] = 1;
               end else begin
                  m_ovf[i] = 1;
               end
            end else if (old_valid && byte_ready) begin
               m_valid[i] = 0;
            end
            m_stuck[i] = stuck_new;
         end
      end
      if (rst) begin
         dly0 = 0;
         dly1 = 0;
      end else begin
         dly1 = dly0;
         dly0 = rnd_in;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Per-cycle comparison of every instance against the model
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_on) begin
            for (int i = 0; i < 3; i++) begin
               check($sformatf("model_valid_u%0d", i), d_vld[i], m_valid[i]);
               if (m_valid[i]) check($sformatf("model_byte_u%0d", i), d_out[i], m_data[i]);
               check($sformatf("model_overflow_u%0d", i), d_ovf[i], m_ovf[i]);
               check($sformatf("model_stuck_u%0d", i), d_stk[i], m_stuck[i]);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      rst = 1'b1;
      enable = 1'b0;
      rnd_in = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #2;
      end
      rst = 1'b0;
   endtask

   // Feeds n samples (MSB first) so that the divide-by-1 instance ticks exactly once per sample
   task automatic run_div1(input logic [63:0] bits, input int n);
      for (int c = 0; c < n + 2; c++) begin
         rnd_in = (c < n) ? bits[n-1-c] : 1'b0;
         enable = (c >= 2);
         @(posedge clk);
         #2;
      end
      enable = 1'b0;
   endtask

   int       k1, k4, k16;
   logic [7:0] cap;
   logic [15:0] samp;

   initial begin
      byte_ready = 1'b1;
      do_reset();
      cmp_on = 1'b1;

      // reset state
      check("reset_valid_u1", bv1, 0);
      check("reset_byte_u1", bo1, 8'h00);
      check("reset_overflow_u4", ov4, 0);
      check("reset_stuck_u16", sf16, 0);

      // pairs 10,01,10,01,01,10,01,10 -> 0xA5
      byte_ready = 1'b1;
      run_div1(64'h9966, 16);
      check("a5_valid", bv1, 1);
      check("a5_byte", bo1, 8'hA5);
      @(posedge clk); #2;
      check("a5_valid_one_cycle", bv1, 0);

      // same pairs interleaved with 00 and 11
      run_div1(64'h8791B6, 24);
      check("a5_mixed_valid", bv1, 1);
      check("a5_mixed_byte", bo1, 8'hA5);
      @(posedge clk); #2;
      check("a5_mixed_one_cycle", bv1, 0);

      // 0x3C then 0xC3 with the consumer stalled
      byte_ready = 1'b0;
      run_div1(64'h5AA5A55A, 32);
      check("ovf_valid", bv1, 1);
      check("ovf_byte_kept", bo1, 8'h3C);
      check("ovf_flag", ov1, 1);
      byte_ready = 1'b1;
      @(posedge clk); #2;
      check("ovf_after_transfer", bv1, 0);

      // stuck source
      do_reset();
      check("ovf_cleared_by_reset", ov1, 0);
      rnd_in = 1'b1;
      enable = 1'b1;
      k1 = 0;
      k4 = 0;
      for (int k = 1; k <= 300; k++) begin
         @(posedge clk); #2;
         if (sf1 && k1 == 0) k1 = k;
         if (sf4 && k4 == 0) k4 = k;
         if (k1 != 0 && k4 != 0) break;
      end
      check("stuck_cycle_div1", k1, 34);
      check("stuck_cycle_div4", k4, 128);
      run_div1(64'h9966, 16);
      check("stuck_no_byte_u1", bv1, 0);
      check("stuck_no_byte_u4", bv4, 0);

      // reset mid-byte discards partial bits
      do_reset();
      run_div1(64'h155, 10);
      check("partial_no_byte", bv1, 0);
      do_reset();
      check("partial_reset_valid", bv1, 0);
      run_div1(64'hAAAA, 16);
      check("fresh_ff_valid", bv1, 1);
      check("fresh_ff_byte", bo1, 8'hFF);

      // enable dropped after the first sample of a pair, divide-by-16
      do_reset();
      byte_ready = 1'b1;
      rnd_in = 1'b1;
      enable = 1'b1;
      repeat (16) begin @(posedge clk); #2; end
      enable = 1'b0;
      repeat (40) begin @(posedge clk); #2; end
      samp = 16'h9966;
      k16 = 0;
      cap = 8'h00;
      enable = 1'b1;
      for (int k = 0; k < 300; k++) begin
         rnd_in = (k / 16 < 16) ? samp[15 - k/16] : 1'b0;
         @(posedge clk); #2;
         if (bv16 && k16 == 0) begin
            k16 = k + 1;
            cap = bo16;
         end
      end
      enable = 1'b0;
      check("reenable_byte_cycle", k16, 256);
      check("reenable_byte", cap, 8'hA5);

      // mixed random traffic checked only by the model
      do_reset();
      for (int c = 0; c < 1200; c++) begin
         rnd_in = 1'($urandom_range(0, 1));
         enable = !((c % 300) >= 250 && (c % 300) < 275);
         byte_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #2;
      end
      enable = 1'b0;
      @(posedge clk); #2;

      cmp_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
